router_fsm_nch: RTL and testbench



---
 rtl/router_pkg.sv | 27 ++
 rtl/router_stat_ctr.sv | 43 ++++
 rtl/router_fsm_nch.sv | 186 ++++++++++++++++++
 tb/tb_router_fsm_nch.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the 1xN router controller.
//               State encoding and statistics counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Controller states; DECODE_ADDRESS is the reset/idle state.
    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    // Width of the optional packet/drop statistics counters.
    localparam int STAT_W = 16;

endpackage
`default_nettype wire

// File: rtl/router_stat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : router_stat_ctr
// Description : Saturating up-counter used for router statistics. Counts
//               once per cycle with i_inc high, sticks at all-ones, and is
//               cleared only by rst.
// Revision    : 1.0 - initial release
// ============================================================================
module router_stat_ctr
    import router_pkg::*;
#(
    parameter int WIDTH = STAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/router_fsm_nch.sv
`default_nettype none
// ============================================================================
// Module      : router_fsm_nch
// Description : Controller FSM for a 1xN packet router. Decodes the header
//               address, sequences header/payload/parity writes into the
//               selected FIFO, handles FIFO-full stalls and per-channel soft
//               resets, and discards packets sent to nonexistent channels.
//               Optional macro ROUTER_FSM_STATS_EN adds pkt_count and
//               drop_count saturating statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic [ADDR_W-1:0] dest_sel
`ifdef ROUTER_FSM_STATS_EN
    ,
    output logic [STAT_W-1:0] pkt_count,
    output logic [STAT_W-1:0] drop_count
`endif
);

    // Per-channel flags are widened to the full address space so any
    // address value can index them; the unused upper entries read as 0.
    localparam int              NPAD     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] dest_sel_q;
    logic [ADDR_W-1:0] dest_sel_d;
    logic [NPAD-1:0]   w_empty_pad;
    logic [NPAD-1:0]   w_srst_pad;
    logic              w_addr_ok;
    logic              w_soft_rst;

    assign w_empty_pad = NPAD'(fifo_empty);
    assign w_srst_pad  = NPAD'(soft_reset);
    assign w_addr_ok   = ({1'b0, data_in} < NUM_CH_W);
    assign w_soft_rst  = w_srst_pad[dest_sel_q];

    // State and destination registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= DECODE_ADDRESS;
            dest_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
        end
    end

    // Next-state logic; a soft reset of the active channel overrides all
    // transitions while a packet is being written into its FIFO.
    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!w_addr_ok) begin
                        state_d = DROP_PACKET;
                    end else begin
                        dest_sel_d = data_in;
                        state_d    = w_empty_pad[data_in] ? LOAD_FIRST_DATA
                                                          : WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            WAIT_TILL_EMPTY: begin
                if (w_empty_pad[dest_sel_q]) state_d = LOAD_FIRST_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET: begin
                if (!pkt_valid) state_d = DECODE_ADDRESS;
            end
            default:            state_d = DECODE_ADDRESS;
        endcase
        if (w_soft_rst && (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET)) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // Moore strobes from the present state; everything is forced low in reset.
    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        drop_state    = 1'b0;
        case (state_q)
            DECODE_ADDRESS:     detect_add = pkt_valid;
            LOAD_FIRST_DATA:    begin busy = 1'b1; lfd_state = 1'b1; end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
            FIFO_FULL_STATE:    begin busy = 1'b1; full_state = 1'b1; end
            LOAD_AFTER_FULL:    begin busy = 1'b1; laf_state = 1'b1; write_enb_reg = 1'b1; end
            LOAD_PARITY:        begin busy = 1'b1; write_enb_reg = 1'b1; end
            CHECK_PARITY_ERROR: begin busy = 1'b1; rst_int_reg = 1'b1; end
            DROP_PACKET:        drop_state = 1'b1;
            default:            busy = 1'b0;
        endcase
        if (reset) begin
            busy          = 1'b0;
            detect_add    = 1'b0;
            lfd_state     = 1'b0;
            ld_state      = 1'b0;
            laf_state     = 1'b0;
            full_state    = 1'b0;
            write_enb_reg = 1'b0;
            rst_int_reg   = 1'b0;
            drop_state    = 1'b0;
        end
    end

    assign dest_sel = reset ? '0 : dest_sel_q;

`ifdef ROUTER_FSM_STATS_EN
    logic [STAT_W-1:0] w_pkt_cnt;
    logic [STAT_W-1:0] w_drop_cnt;
    logic              w_pkt_inc;
    logic              w_drop_inc;

    // One count per cycle in LOAD_FIRST_DATA; one per entry into DROP_PACKET.
    assign w_pkt_inc  = (state_q == LOAD_FIRST_DATA);
    assign w_drop_inc = (state_q == DECODE_ADDRESS) && (state_d == DROP_PACKET);

    router_stat_ctr #(.WIDTH(STAT_W)) u_pkt_ctr (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (w_pkt_inc),
        .o_count (w_pkt_cnt)
    );

    router_stat_ctr #(.WIDTH(STAT_W)) u_drop_ctr (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (w_drop_inc),
        .o_count (w_drop_cnt)
    );

    assign pkt_count  = reset ? '0 : w_pkt_cnt;
    assign drop_count = reset ? '0 : w_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_nch.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fsm_nch
// Description : Self-checking bench for router_fsm_nch. Instance A (3 ch) is
//               followed cycle by cycle by a rule-level reference model;
//               instance B (8 ch) is checked with literal expectations.
//               Statistics checks are active when ROUTER_FSM_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm_nch;

    localparam int A_CH = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: NUM_CH=3, ADDR_W=2 ----------------
    logic       a_pv, a_pd, a_lpv, a_ff;
    logic [1:0] a_din;
    logic [2:0] a_fe, a_sr;
    logic       a_busy, a_det, a_lfd, a_ld, a_laf, a_full, a_wen, a_rst, a_drop;
    logic [1:0] a_dest;
    logic [8:0] a_vec;
    assign a_vec = {a_busy, a_det, a_lfd, a_ld, a_laf, a_full, a_wen, a_rst, a_drop};

    // ---------------- instance B: NUM_CH=8, ADDR_W=3 ----------------
    logic       b_pv;
    logic [2:0] b_din;
    logic [7:0] b_fe;
    logic       b_busy, b_det, b_lfd, b_ld, b_laf, b_full, b_wen, b_rst, b_drop;
    logic [2:0] b_dest;
    logic [8:0] b_vec;
    assign b_vec = {b_busy, b_det, b_lfd, b_ld, b_laf, b_full, b_wen, b_rst, b_drop};

`ifdef ROUTER_FSM_STATS_EN
    logic [15:0] a_pkt_cnt, a_drop_cnt, b_pkt_cnt, b_drop_cnt;
`endif

    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2)) u_dut_a (
        .clock(clock), .reset(reset), .pkt_valid(a_pv), .data_in(a_din),
        .parity_done(a_pd), .low_pkt_valid(a_lpv), .fifo_full(a_ff),
        .fifo_empty(a_fe), .soft_reset(a_sr), .busy(a_busy), .detect_add(a_det),
        .lfd_state(a_lfd), .ld_state(a_ld), .laf_state(a_laf), .full_state(a_full),
        .write_enb_reg(a_wen), .rst_int_reg(a_rst), .drop_state(a_drop),
        .dest_sel(a_dest)
`ifdef ROUTER_FSM_STATS_EN
        , .pkt_count(a_pkt_cnt), .drop_count(a_drop_cnt)
`endif
    );

    router_fsm_nch #(.NUM_CH(8), .ADDR_W(3)) u_dut_b (
        .clock(clock), .reset(reset), .pkt_valid(b_pv), .data_in(b_din),
        .parity_done(1'b0), .low_pkt_valid(1'b0), .fifo_full(1'b0),
        .fifo_empty(b_fe), .soft_reset(8'h00), .busy(b_busy), .detect_add(b_det),
        .lfd_state(b_lfd), .ld_state(b_ld), .laf_state(b_laf), .full_state(b_full),
        .write_enb_reg(b_wen), .rst_int_reg(b_rst), .drop_state(b_drop),
        .dest_sel(b_dest)
`ifdef ROUTER_FSM_STATS_EN
        , .pkt_count(b_pkt_cnt), .drop_count(b_drop_cnt)
`endif
    );

    // ---------------- reference model for instance A ----------------
    // Phase names describe where the packet is; transitions follow the
    // controller's rules written out directly.
    string m_st    = "UNKNOWN";
    bit    m_known = 1'b0;
    int    m_dest  = 0;
    int    m_pkt   = 0;
    int    m_drop  = 0;

    always @(posedge clock) begin : ref_model
        string nx;
        int    nd;
        if (reset) begin
            m_st = "DECODE"; m_dest = 0; m_pkt = 0; m_drop = 0; m_known = 1'b1;
        end else if (m_known) begin
            nx = m_st;
            nd = m_dest;
            if (m_st == "DECODE") begin
                if (a_pv) begin
                    if (int'(a_din) >= A_CH) begin
                        nx = "DROP";
                        m_drop++;
                    end else begin
                        nd = int'(a_din);
                        nx = a_fe[nd] ? "LFD" : "WAIT";
                    end
                end
            end else if (m_st == "LFD")  nx = "LD";
            else if (m_st == "WAIT")     nx = a_fe[m_dest] ? "LFD" : "WAIT";
            else if (m_st == "LD")       nx = a_ff ? "FULL" : (!a_pv ? "LP" : "LD");
            else if (m_st == "FULL")     nx = a_ff ? "FULL" : "LAF";
            else if (m_st == "LAF")      nx = a_pd ? "DECODE" : (a_lpv ? "LP" : "LD");
            else if (m_st == "LP")       nx = "CPE";
            else if (m_st == "CPE")      nx = a_ff ? "FULL" : "DECODE";
            else if (m_st == "DROP")     nx = a_pv ? "DROP" : "DECODE";
            if (m_st != "DECODE" && m_st != "DROP" && a_sr[m_dest]) nx = "DECODE";
            if (m_st == "LFD" && m_pkt < 65535) m_pkt++;
            m_st   = nx;
            m_dest = nd;
        end
    end

    function automatic logic [8:0] model_strobes();
        logic [8:0] s;
        s = '0;
        if (!reset) begin
            s[8] = (m_st == "LFD") || (m_st == "WAIT") || (m_st == "FULL") ||
                   (m_st == "LAF") || (m_st == "LP")   || (m_st == "CPE");
            s[7] = (m_st == "DECODE") && a_pv;
            s[6] = (m_st == "LFD");
            s[5] = (m_st == "LD");
            s[4] = (m_st == "LAF");
            s[3] = (m_st == "FULL");
            s[2] = (m_st == "LD") || (m_st == "LAF") || (m_st == "LP");
            s[1] = (m_st == "CPE");
            s[0] = (m_st == "DROP");
        end
        return s;
    endfunction

    // Per-cycle comparison of instance A against the model.
    always @(negedge clock) begin : compare
        logic [10:0] exp_v;
        logic [10:0] act_v;
        if (reset || m_known) begin
            exp_v = {model_strobes(), reset ? 2'b00 : 2'(m_dest)};
            act_v = {a_vec, a_dest};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t phase=%s actual=%b required=%b",
                         $time, m_st, act_v, exp_v);
            end
`ifdef ROUTER_FSM_STATS_EN
            checks++;
            if ({a_pkt_cnt, a_drop_cnt} !== {16'(m_pkt), 16'(m_drop)}) begin
                failures++;
                $display("FAIL stats_compare t=%0t actual=%0d/%0d required=%0d/%0d",
                         $time, a_pkt_cnt, a_drop_cnt, m_pkt, m_drop);
            end
`endif
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic pv, input logic [1:0] din, input logic ff,
                           input logic lpv, input logic pd, input logic [2:0] fe,
                           input logic [2:0] sr);
        a_pv = pv; a_din = din; a_ff = ff; a_lpv = lpv; a_pd = pd; a_fe = fe; a_sr = sr;
        #1;
    endtask

    task automatic drive_b(input logic pv, input logic [2:0] din);
        b_pv = pv; b_din = din; b_fe = 8'hFF;
        #1;
    endtask

    // Strobe vectors {busy,detect,lfd,ld,laf,full,wen,rst_int,drop}
    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_DET  = 9'b010000000;
    localparam logic [8:0] V_LFD  = 9'b101000000;
    localparam logic [8:0] V_WAIT = 9'b100000000;
    localparam logic [8:0] V_LD   = 9'b000100100;
    localparam logic [8:0] V_FULL = 9'b100001000;
    localparam logic [8:0] V_LAF  = 9'b100010100;
    localparam logic [8:0] V_LP   = 9'b100000100;
    localparam logic [8:0] V_CPE  = 9'b100000010;
    localparam logic [8:0] V_DROP = 9'b000000001;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        reset = 1'b1;
        a_pv = 1'b1; a_din = 2'd1; a_ff = 1'b0; a_lpv = 1'b0; a_pd = 1'b0;
        a_fe = 3'b111; a_sr = 3'b000;
        b_pv = 1'b1; b_din = 3'd5; b_fe = 8'hFF;
        tick(); tick();
        // Outputs held low during reset even with a header on the bus.
        chk("reset_outputs_a", {a_vec, a_dest}, 32'd0);
        chk("reset_outputs_b", {b_vec, b_dest}, 32'd0);
        reset = 1'b0;
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        b_pv = 1'b0;
        chk("post_reset_idle", {a_vec, a_dest}, 32'd0);
        tick();

        // Packet to channel 1, empty FIFO, 4 payload cycles.
        drive_a(1, 1, 0, 0, 0, 3'b111, 3'b000);
        chk("hdr_detect", a_vec, V_DET);
        tick();
        drive_a(1, 2, 0, 0, 0, 3'b111, 3'b000);
        chk("hdr_lfd", {a_vec, a_dest}, {V_LFD, 2'd1});
        tick();
        drive_a(1, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("first_ld", {a_vec, a_dest}, {V_LD, 2'd1});
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_a(1, 3, 0, 0, 0, 3'b111, 3'b000);
            tick();
        end
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("last_ld", a_vec, V_LD);
        tick();
        chk("load_parity", a_vec, V_LP);
        tick();
        chk("check_parity", a_vec, V_CPE);
        tick();
        chk("back_to_decode", {a_vec, a_dest}, {V_IDLE, 2'd1});

        // Packet to nonexistent channel 3 is dropped; soft reset ignored there.
        drive_a(1, 3, 0, 0, 0, 3'b111, 3'b000);
        chk("drop_detect", a_vec, V_DET);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_a(1, 2, 0, 0, 0, 3'b111, (i == 1) ? 3'b010 : 3'b000);
            chk("drop_body", {a_vec, a_dest}, {V_DROP, 2'd1});
            tick();
        end
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("drop_exit_cycle", a_vec, V_DROP);
        tick();
        chk("drop_done", {a_vec, a_dest}, {V_IDLE, 2'd1});
`ifdef ROUTER_FSM_STATS_EN
        chk("drop_count", 32'(a_drop_cnt), 32'd1);
`endif

        // Channel 2 not empty: wait, then full stall with low_pkt_valid.
        drive_a(1, 2, 0, 0, 0, 3'b011, 3'b000);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_a(1, 1, 0, 0, 0, 3'b011, 3'b000);
            chk("wait_empty", {a_vec, a_dest}, {V_WAIT, 2'd2});
            tick();
        end
        drive_a(1, 1, 0, 0, 0, 3'b111, 3'b000);
        chk("wait_release", a_vec, V_WAIT);
        tick();
        chk("wait_lfd", {a_vec, a_dest}, {V_LFD, 2'd2});
        tick();
        drive_a(1, 0, 1, 0, 0, 3'b111, 3'b000);
        chk("ld_before_full", a_vec, V_LD);
        tick();
        drive_a(1, 0, 1, 0, 0, 3'b111, 3'b000);
        chk("full_state", a_vec, V_FULL);
        tick();
        drive_a(0, 0, 0, 1, 0, 3'b111, 3'b000);
        chk("full_release", a_vec, V_FULL);
        tick();
        drive_a(0, 0, 0, 1, 0, 3'b111, 3'b000);
        chk("load_after_full", a_vec, V_LAF);
        tick();
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("laf_to_parity", a_vec, V_LP);
        tick();
        tick();
        chk("full_pkt_done", a_vec, V_IDLE);

        // Soft reset: wrong channel ignored, own channel aborts next cycle.
        drive_a(1, 1, 0, 0, 0, 3'b111, 3'b000);
        tick();
        tick();
        drive_a(1, 0, 0, 0, 0, 3'b111, 3'b001);
        chk("srst_other_ch", a_vec, V_LD);
        tick();
        drive_a(1, 0, 0, 0, 0, 3'b111, 3'b011);
        chk("srst_still_ld", a_vec, V_LD);
        tick();
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("srst_decode", {a_vec, a_dest}, {V_IDLE, 2'd1});
        tick();

        // Parity check with full FIFO, then LAF exit on parity_done.
        drive_a(1, 0, 0, 0, 0, 3'b111, 3'b000);
        tick();
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        tick();
        tick();
        tick();
        drive_a(0, 0, 1, 0, 0, 3'b111, 3'b000);
        chk("cpe_full", a_vec, V_CPE);
        tick();
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("cpe_to_full", a_vec, V_FULL);
        tick();
        drive_a(0, 0, 0, 0, 1, 3'b111, 3'b000);
        chk("laf_parity_done", a_vec, V_LAF);
        tick();
        drive_a(0, 0, 0, 0, 0, 3'b111, 3'b000);
        chk("laf_to_decode", {a_vec, a_dest}, {V_IDLE, 2'd0});
`ifdef ROUTER_FSM_STATS_EN
        chk("pkt_count_a", 32'(a_pkt_cnt), 32'd4);
`endif
        tick();

        // Instance B: back-to-back packets to channels 7 then 0.
        drive_b(1, 7);
        chk("b_detect7", b_vec, V_DET);
        tick();
        drive_b(0, 0);
        chk("b_lfd7", {b_vec, b_dest}, {V_LFD, 3'd7});
        tick();
        chk("b_ld7", b_vec, V_LD);
        tick();
        chk("b_lp7", b_vec, V_LP);
        tick();
        chk("b_cpe7", b_vec, V_CPE);
        tick();
        drive_b(1, 0);
        chk("b_detect0", {b_vec, b_dest}, {V_DET, 3'd7});
        tick();
        drive_b(0, 0);
        chk("b_lfd0", {b_vec, b_dest}, {V_LFD, 3'd0});
        tick();
        tick();
        tick();
        chk("b_cpe0", b_vec, V_CPE);
        tick();
        chk("b_idle", {b_vec, b_dest}, {V_IDLE, 3'd0});
`ifdef ROUTER_FSM_STATS_EN
        chk("b_pkt_count", 32'(b_pkt_cnt), 32'd2);
        chk("b_drop_count", 32'(b_drop_cnt), 32'd0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
